move_sequencer: RTL and testbench

Move sequencer for the Connect4 board datapath. It accepts a column request from the input front-end, validates it against per-column fill heights, and writes the dropped piece into the board RAM. It then runs a handshake with the win checker and decides the next turn or the final game status. It sits between the player input logic and the game-status FSM, supplying `player_turn`, `invalid_move` and `board_full`.

---
 rtl/move_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_move_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Connect4 move sequencer: validates a column request, writes the piece,
// runs the win-check handshake and tracks turn, piece count and status.
//
// Ports:
//   clk, reset, new_game         clock, sync active-high clears
//   move_req, move_col           column request (held until move_ack)
//   move_ack, invalid_move       completion / rejection pulses
//   wr_en, wr_row, wr_col,       board RAM write strobe and cell
//   wr_data
//   chk_start, chk_row, chk_col  win-checker start and last placed cell
//   chk_done, chk_win            win-checker result
//   player_turn, piece_count,    game state
//   board_full, game_status
//   busy                         high while a move is being processed
module move_sequencer #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_req,
    input  logic [2:0] move_col,
    output logic       move_ack,
    output logic       invalid_move,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       chk_start,
    output logic [2:0] chk_row,
    output logic [2:0] chk_col,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic       player_turn,
    output logic [5:0] piece_count,
    output logic       board_full,
    output logic [1:0] game_status,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
        S_REJECT,
        S_WRITE,
        S_CHECK,
        S_WAIT_CHK,
        S_ACK,
        S_OVER
    } state_t;

    localparam logic [5:0] CELLS_W = 6'(ROWS * COLS);
    localparam logic [2:0] ROWS_W  = 3'(ROWS);
    localparam logic [3:0] COLS_W  = 4'(COLS);

    state_t     state_q;
    // Eight slots so any 3-bit column indexes a real entry;
    // slots at or above COLS are never written.
    logic [2:0] height_q [8];
    logic [2:0] col_q;
    logic       move_ack_q;
    logic       invalid_q;
    logic       wr_en_q;
    logic [2:0] wr_row_q;
    logic [2:0] wr_col_q;
    logic [1:0] wr_data_q;
    logic       chk_start_q;
    logic [2:0] chk_row_q;
    logic [2:0] chk_col_q;
    logic       turn_q;
    logic [5:0] count_q;
    logic       full_q;
    logic [1:0] status_q;
    logic       busy_q;

    logic       col_ok_d;
    logic [2:0] cur_h_d;
    logic       reject_d;
    logic [5:0] count_d;

    always_comb begin
        col_ok_d = ({1'b0, col_q} < COLS_W);
        cur_h_d  = height_q[col_q];
        reject_d = !col_ok_d || (cur_h_d >= ROWS_W) ||
                   (status_q != 2'b00);
        count_d  = count_q + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                height_q[i] <= 3'd0;
            end
            col_q       <= 3'd0;
            move_ack_q  <= 1'b0;
            invalid_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_row_q    <= 3'd0;
            wr_col_q    <= 3'd0;
            wr_data_q   <= 2'b00;
            chk_start_q <= 1'b0;
            chk_row_q   <= 3'd0;
            chk_col_q   <= 3'd0;
            turn_q      <= 1'b0;
            count_q     <= 6'd0;
            full_q      <= 1'b0;
            status_q    <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            move_ack_q  <= 1'b0;
            invalid_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            chk_start_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (move_req) begin
                        col_q   <= move_col;
                        busy_q  <= 1'b1;
                        state_q <= S_VALIDATE;
                    end
                end

                // A finished game routes through VALIDATE too, so
                // rejections keep the same two-cycle latency.
                S_VALIDATE: begin
                    if (reject_d) begin
                        move_ack_q <= 1'b1;
                        invalid_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_REJECT;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_row_q  <= cur_h_d;
                        wr_col_q  <= col_q;
                        wr_data_q <= {turn_q, ~turn_q};
                        chk_row_q <= cur_h_d;
                        chk_col_q <= col_q;
                        height_q[col_q] <= cur_h_d + 3'd1;
                        count_q   <= count_d;
                        full_q    <= (count_d == CELLS_W);
                        state_q   <= S_WRITE;
                    end
                end

                S_REJECT: begin
                    state_q <= (status_q != 2'b00) ? S_OVER : S_IDLE;
                end

                S_WRITE: begin
                    chk_start_q <= 1'b1;
                    state_q     <= S_CHECK;
                end

                S_CHECK: begin
                    state_q <= S_WAIT_CHK;
                end

                S_WAIT_CHK: begin
                    if (chk_done) begin
                        move_ack_q <= 1'b1;
                        busy_q     <= 1'b0;
                        if (chk_win) begin
                            status_q <= turn_q ? 2'b10 : 2'b01;
                            state_q  <= S_OVER;
                        end else if (full_q) begin
                            status_q <= 2'b11;
                            state_q  <= S_OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= S_ACK;
                        end
                    end
                end

                S_ACK: begin
                    state_q <= S_IDLE;
                end

                // The ack cycle right after a final move still sees
                // the finishing request; skip it.
                S_OVER: begin
                    if (move_req && !move_ack_q) begin
                        col_q   <= move_col;
                        busy_q  <= 1'b1;
                        state_q <= S_VALIDATE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign move_ack     = move_ack_q;
    assign invalid_move = invalid_q;
    assign wr_en        = wr_en_q;
    assign wr_row       = wr_row_q;
    assign wr_col       = wr_col_q;
    assign wr_data      = wr_data_q;
    assign chk_start    = chk_start_q;
    assign chk_row      = chk_row_q;
    assign chk_col      = chk_col_q;
    assign player_turn  = turn_q;
    assign piece_count  = count_q;
    assign board_full   = full_q;
    assign game_status  = status_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a reference model and an
// expected-result queue checked against the DUT outputs.
module tb_move_sequencer;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       move_req = 1'b0;
    logic [2:0] move_col = 3'd0;
    logic       move_ack;
    logic       invalid_move;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_data;
    logic       chk_start;
    logic [2:0] chk_row;
    logic [2:0] chk_col;
    logic       chk_done = 1'b0;
    logic       chk_win = 1'b0;
    logic       player_turn;
    logic [5:0] piece_count;
    logic       board_full;
    logic [1:0] game_status;
    logic       busy;

    move_sequencer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk),
        .reset(reset),
        .new_game(new_game),
        .move_req(move_req),
        .move_col(move_col),
        .move_ack(move_ack),
        .invalid_move(invalid_move),
        .wr_en(wr_en),
        .wr_row(wr_row),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .chk_start(chk_start),
        .chk_row(chk_row),
        .chk_col(chk_col),
        .chk_done(chk_done),
        .chk_win(chk_win),
        .player_turn(player_turn),
        .piece_count(piece_count),
        .board_full(board_full),
        .game_status(game_status),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rej;
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] data;
        logic       pt;
        logic [5:0] cnt;
        logic       full;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_h[8];
    int         m_cnt;
    bit         m_pt;
    logic [1:0] m_st;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_h[i] = 0;
        m_cnt = 0;
        m_pt  = 1'b0;
        m_st  = 2'b00;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".ack"}, 32'(move_ack), 0);
        check({tag, ".inv"}, 32'(invalid_move), 0);
        check({tag, ".wr_en"}, 32'(wr_en), 0);
        check({tag, ".chk_start"}, 32'(chk_start), 0);
        check({tag, ".turn"}, 32'(player_turn), 0);
        check({tag, ".count"}, 32'(piece_count), 0);
        check({tag, ".full"}, 32'(board_full), 0);
        check({tag, ".status"}, 32'(game_status), 0);
        check({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset(input bit use_ng);
        @(posedge clk); #1;
        if (use_ng) new_game = 1'b1;
        else reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        new_game = 1'b0;
        model_clear();
        @(negedge clk);
        check_idle_zero("rst");
        check("rst.wr_row", 32'(wr_row), 0);
        check("rst.wr_col", 32'(wr_col), 0);
        check("rst.wr_data", 32'(wr_data), 0);
        check("rst.chk_row", 32'(chk_row), 0);
        check("rst.chk_col", 32'(chk_col), 0);
    endtask

    task automatic move(input int col, input bit win);
        exp_t e;
        exp_t g;
        e.rej  = (m_st != 2'b00) || (col >= COLS) || (m_h[col] >= ROWS);
        e.row  = 3'(m_h[col]);
        e.col  = 3'(col);
        e.data = m_pt ? 2'b10 : 2'b01;
        if (!e.rej) begin
            m_h[col]++;
            m_cnt++;
            if (win) m_st = m_pt ? 2'b10 : 2'b01;
            else if (m_cnt == ROWS * COLS) m_st = 2'b11;
            else m_pt = !m_pt;
        end
        e.pt   = m_pt;
        e.cnt  = 6'(m_cnt);
        e.full = (m_cnt == ROWS * COLS);
        e.st   = m_st;
        exp_q.push_back(e);

        @(posedge clk); #1;
        move_req = 1'b1;
        move_col = 3'(col);
        @(posedge clk);
        @(negedge clk);
        check("t1.busy", 32'(busy), 1);
        check("t1.ack", 32'(move_ack), 0);
        @(negedge clk);
        g = exp_q.pop_front();
        if (g.rej) begin
            check("rej.ack", 32'(move_ack), 1);
            check("rej.inv", 32'(invalid_move), 1);
            check("rej.wr_en", 32'(wr_en), 0);
            check("rej.busy", 32'(busy), 0);
        end else begin
            check("wr.en", 32'(wr_en), 1);
            check("wr.row", 32'(wr_row), 32'(g.row));
            check("wr.col", 32'(wr_col), 32'(g.col));
            check("wr.data", 32'(wr_data), 32'(g.data));
            check("wr.ack", 32'(move_ack), 0);
            @(negedge clk);
            check("chk.start", 32'(chk_start), 1);
            check("chk.row", 32'(chk_row), 32'(g.row));
            check("chk.col", 32'(chk_col), 32'(g.col));
            @(posedge clk); #1;
            chk_done = 1'b1;
            chk_win  = win;
            @(posedge clk); #1;
            chk_done = 1'b0;
            chk_win  = 1'b0;
            @(negedge clk);
            check("done.ack", 32'(move_ack), 1);
            check("done.inv", 32'(invalid_move), 0);
            check("done.busy", 32'(busy), 0);
        end
        move_req = 1'b0;
        check("res.turn", 32'(player_turn), 32'(g.pt));
        check("res.count", 32'(piece_count), 32'(g.cnt));
        check("res.full", 32'(board_full), 32'(g.full));
        check("res.status", 32'(game_status), 32'(g.st));
        @(negedge clk);
        check("post.ack", 32'(move_ack), 0);
        check("post.wr_en", 32'(wr_en), 0);
        check("post.busy", 32'(busy), 0);
    endtask

    task automatic abort_wait(input bit use_ng);
        @(posedge clk); #1;
        move_req = 1'b1;
        move_col = 3'd5;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("ab.busy", 32'(busy), 1);
        check("ab.chk_col", 32'(chk_col), 5);
        move_req = 1'b0;
        if (use_ng) new_game = 1'b1;
        else reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        new_game = 1'b0;
        model_clear();
        @(negedge clk);
        check_idle_zero("ab");
        check("ab.chk_row", 32'(chk_row), 0);
        @(posedge clk); #1;
        chk_done = 1'b1;
        chk_win  = 1'b1;
        @(posedge clk); #1;
        chk_done = 1'b0;
        chk_win  = 1'b0;
        @(negedge clk);
        check_idle_zero("late");
        @(negedge clk);
        check_idle_zero("late2");
    endtask

    task automatic fill(input bit win_last);
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                move(c, win_last && (c == COLS - 1) && (r == ROWS - 1));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        do_reset(1'b0);

        move(3, 1'b0);

        for (int i = 0; i < ROWS; i++) move(0, 1'b0);
        move(0, 1'b0);
        move(7, 1'b0);

        move(1, 1'b1);
        move(2, 1'b0);
        move(7, 1'b0);

        do_reset(1'b0);
        fill(1'b0);
        move(4, 1'b0);

        do_reset(1'b1);
        fill(1'b1);

        do_reset(1'b0);
        move(5, 1'b0);
        abort_wait(1'b0);
        move(5, 1'b0);
        move(5, 1'b0);
        abort_wait(1'b1);
        move(5, 1'b0);

        check("queue.empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
